// File: rtl/cordic_pkg.sv
// Types shared by the cordic datapath: the default operand width, the
// fixed-point word type and the initiator state encoding.
package cordic_pkg;

    localparam int DEFAULT_DATA_W = 23;

    typedef logic signed [DEFAULT_DATA_W-1:0] fixed_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        HOLD
    } init_state_t;

endpackage

// File: rtl/cordic_initiator.sv
// Initiator side of the cordic start/done handshake: issues one operand at a
// time, waits for done with a timeout, and keeps a running sum of results.
module cordic_initiator
    import cordic_pkg::*;
#(
    parameter int DATA_W  = DEFAULT_DATA_W,
    parameter int ACC_W   = 32,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_theta,
    output logic              co_clk_en,
    output logic              co_start,
    output logic [DATA_W-1:0] co_theta,
    input  logic              co_done,
    input  logic [DATA_W-1:0] co_result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic              out_timeout,
    input  logic              acc_clear,
    output logic [ACC_W-1:0]  acc_sum,
    output logic [15:0]       result_count
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    init_state_t      state;
    init_state_t      state_next;
    logic [CNT_W-1:0] wait_cnt;
    logic             live;
    logic             accept;
    logic             add;
    logic             timed_out;
    logic [ACC_W-1:0] add_value;

    // live keeps in_ready low on the reset cycle itself, so it rises only
    // on the first cycle after reset is released.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            live  <= 1'b0;
        end else begin
            state <= state_next;
            live  <= 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        co_start   = 1'b0;
        co_clk_en  = 1'b0;
        out_valid  = 1'b0;
        accept     = 1'b0;
        add        = 1'b0;
        timed_out  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = live;
                if (in_valid && live) begin
                    accept     = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                co_start   = 1'b1;
                co_clk_en  = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                co_clk_en = 1'b1;
                // done takes priority over a timeout landing in the same cycle
                if (co_done) begin
                    add        = 1'b1;
                    state_next = HOLD;
                end else if (wait_cnt == CNT_LAST) begin
                    timed_out  = 1'b1;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign add_value = add ? ACC_W'($signed(co_result)) : '0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            wait_cnt     <= '0;
            co_theta     <= '0;
            out_result   <= '0;
            out_timeout  <= 1'b0;
            acc_sum      <= '0;
            result_count <= '0;
        end else begin
            if (accept) begin
                co_theta <= in_theta;
            end
            if (state == ISSUE) begin
                wait_cnt <= '0;
            end else if (state == WAIT) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end
            if (add) begin
                out_result  <= co_result;
                out_timeout <= 1'b0;
            end else if (timed_out) begin
                out_result  <= '0;
                out_timeout <= 1'b1;
            end
            // a clear coincident with a result keeps only that result
            acc_sum      <= (acc_clear ? '0 : acc_sum) + add_value;
            result_count <= (acc_clear ? 16'd0 : result_count) + (add ? 16'd1 : 16'd0);
        end
    end

endmodule

// File: tb/tb_cordic_initiator.sv
// Self-checking bench for cordic_initiator: the bench plays the responder and
// consumer, and predicts every output from a cycle-level transaction model.
module tb_cordic_initiator;

    localparam int DATA_W  = 23;
    localparam int ACC_W   = 32;
    localparam int TIMEOUT = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_theta = '0;
    logic              co_clk_en;
    logic              co_start;
    logic [DATA_W-1:0] co_theta;
    logic              co_done = 1'b0;
    logic [DATA_W-1:0] co_result = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_result;
    logic              out_timeout;
    logic              acc_clear = 1'b0;
    logic [ACC_W-1:0]  acc_sum;
    logic [15:0]       result_count;

    always #5 clk = ~clk;

    cordic_initiator #(
        .DATA_W  (DATA_W),
        .ACC_W   (ACC_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_theta     (in_theta),
        .co_clk_en    (co_clk_en),
        .co_start     (co_start),
        .co_theta     (co_theta),
        .co_done      (co_done),
        .co_result    (co_result),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_timeout  (out_timeout),
        .acc_clear    (acc_clear),
        .acc_sum      (acc_sum),
        .result_count (result_count)
    );

    int checkCount = 0;
    int errorCount = 0;

    logic [31:0] modelSum = '0;
    logic [15:0] modelCount = '0;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Results are two's complement DATA_W-bit words; the sum is taken as integers mod 2^32.
    task automatic modelAccumulate(input logic [DATA_W-1:0] result, input bit clear);
        int value;
        value = int'(result);
        if (result[DATA_W-1]) value = value - (1 << DATA_W);
        modelSum   = clear ? 32'(value) : modelSum + 32'(value);
        modelCount = clear ? 16'd1 : modelCount + 16'd1;
    endtask

    task automatic clearAccumulator();
        @(negedge clk);
        out_ready = 1'b0;
        co_done   = 1'b0;
        acc_clear = 1'b1;
        @(negedge clk);
        acc_clear  = 1'b0;
        modelSum   = '0;
        modelCount = '0;
        checkOutput("clear_sum", acc_sum, modelSum);
        checkOutput("clear_count", result_count, modelCount);
    endtask

    // One full transaction. k = cycle of WAIT (1-based) in which done arrives;
    // k outside 1..TIMEOUT means the responder never answers.
    task automatic applyStimulus(input logic [DATA_W-1:0] theta, input int k,
                                 input logic [DATA_W-1:0] result, input int holdCycles,
                                 input bit clearAtDone, input bit staleDone,
                                 input bit pend, input logic [DATA_W-1:0] pendTheta);
        int last;
        bit gotDone;
        logic [DATA_W-1:0] heldResult;
        @(negedge clk);
        checkOutput("idle_in_ready", in_ready, 1);
        checkOutput("idle_out_valid", out_valid, 0);
        checkOutput("idle_clk_en", co_clk_en, 0);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_theta  = theta;
        co_done   = 1'b0;
        @(negedge clk);
        checkOutput("issue_start", co_start, 1);
        checkOutput("issue_clk_en", co_clk_en, 1);
        checkOutput("issue_in_ready", in_ready, 0);
        checkOutput("issue_theta", co_theta, theta);
        in_valid  = pend;
        in_theta  = pend ? pendTheta : DATA_W'($urandom);
        co_done   = staleDone;
        co_result = DATA_W'($urandom);
        gotDone = (k >= 1) && (k <= TIMEOUT);
        last = gotDone ? k : TIMEOUT;
        for (int c = 1; c <= last; c++) begin
            @(negedge clk);
            checkOutput("wait_start", co_start, 0);
            checkOutput("wait_clk_en", co_clk_en, 1);
            checkOutput("wait_out_valid", out_valid, 0);
            checkOutput("wait_in_ready", in_ready, 0);
            checkOutput("wait_theta", co_theta, theta);
            co_done   = (c == k);
            co_result = (c == k) ? result : DATA_W'($urandom);
            acc_clear = clearAtDone && (c == k);
        end
        @(negedge clk);
        co_done   = 1'b0;
        acc_clear = 1'b0;
        if (gotDone) modelAccumulate(result, clearAtDone);
        heldResult = gotDone ? result : '0;
        checkOutput("hold_out_valid", out_valid, 1);
        checkOutput("hold_result", out_result, heldResult);
        checkOutput("hold_timeout", out_timeout, !gotDone);
        checkOutput("hold_sum", acc_sum, modelSum);
        checkOutput("hold_count", result_count, modelCount);
        checkOutput("hold_clk_en", co_clk_en, 0);
        checkOutput("hold_in_ready", in_ready, 0);
        for (int h = 0; h < holdCycles; h++) begin
            out_ready = 1'b0;
            co_done   = staleDone ? 1'($urandom) : 1'b0;
            co_result = DATA_W'($urandom);
            @(negedge clk);
            checkOutput("bp_out_valid", out_valid, 1);
            checkOutput("bp_result", out_result, heldResult);
            checkOutput("bp_timeout", out_timeout, !gotDone);
            checkOutput("bp_in_ready", in_ready, 0);
            checkOutput("bp_start", co_start, 0);
            checkOutput("bp_sum", acc_sum, modelSum);
            checkOutput("bp_count", result_count, modelCount);
        end
        out_ready = 1'b1;
        co_done   = staleDone;
    endtask

    task automatic resetMidWait();
        @(negedge clk);
        out_ready = 1'b0;
        co_done   = 1'b0;
        in_valid  = 1'b1;
        in_theta  = DATA_W'($urandom);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_in_wait", co_clk_en, 1);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("rst_in_ready", in_ready, 0);
        checkOutput("rst_start", co_start, 0);
        checkOutput("rst_clk_en", co_clk_en, 0);
        checkOutput("rst_theta", co_theta, 0);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_result", out_result, 0);
        checkOutput("rst_timeout", out_timeout, 0);
        checkOutput("rst_sum", acc_sum, 0);
        checkOutput("rst_count", result_count, 0);
        reset     = 1'b1;
        co_done   = 1'b1;
        co_result = DATA_W'($urandom);
        @(negedge clk);
        checkOutput("rel_in_ready", in_ready, 1);
        checkOutput("rel_out_valid", out_valid, 0);
        checkOutput("rel_sum", acc_sum, 0);
        checkOutput("rel_count", result_count, 0);
        co_done    = 1'b0;
        modelSum   = '0;
        modelCount = '0;
    endtask

    initial begin
        $display("[TB] cordic_initiator bench starting");
        repeat (3) @(negedge clk);
        checkOutput("por_in_ready", in_ready, 0);
        checkOutput("por_out_valid", out_valid, 0);
        checkOutput("por_sum", acc_sum, 0);
        checkOutput("por_count", result_count, 0);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("por_release_ready", in_ready, 1);

        applyStimulus(23'h200000, 3, 23'h1B5C28, 0, 0, 0, 0, '0);
        checkOutput("single_sum", acc_sum, 32'h001B5C28);
        checkOutput("single_count", result_count, 16'd1);

        clearAccumulator();
        applyStimulus(23'h012345, 2, 23'h7FFFFF, 0, 0, 0, 0, '0);
        checkOutput("neg_sum_1", acc_sum, 32'hFFFFFFFF);
        applyStimulus(23'h054321, 1, 23'h000005, 1, 0, 0, 0, '0);
        checkOutput("neg_sum_2", acc_sum, 32'h00000004);
        checkOutput("neg_count", result_count, 16'd2);

        applyStimulus(23'h0ABCDE, 0, '0, 0, 0, 0, 0, '0);
        checkOutput("timeout_sum", acc_sum, 32'h00000004);

        applyStimulus(23'h111111, 2, 23'h2468AC, 5, 0, 1, 1, 23'h222222);
        applyStimulus(23'h222222, 4, 23'h13579B, 0, 0, 0, 0, '0);

        clearAccumulator();
        applyStimulus(23'h000100, 2, 23'd100, 0, 0, 0, 0, '0);
        applyStimulus(23'h000200, 3, 23'd7, 0, 1, 0, 0, '0);
        checkOutput("collide_sum", acc_sum, 32'd7);
        checkOutput("collide_count", result_count, 16'd1);

        resetMidWait();
        applyStimulus(23'h0F0F0F, 1, 23'h400001, 0, 0, 0, 0, '0);

        for (int n = 0; n < 25; n++) begin
            applyStimulus(DATA_W'($urandom), int'($urandom_range(0, 10)), DATA_W'($urandom),
                          int'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0),
                          1'($urandom), 1'b0, '0);
        end

        @(negedge clk);
        out_ready = 1'b0;
        co_done   = 1'b0;
        @(negedge clk);
        checkOutput("final_idle_ready", in_ready, 1);
        checkOutput("final_sum", acc_sum, modelSum);
        checkOutput("final_count", result_count, modelCount);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/cordic_initiator.md
# cordic_initiator

Initiator side of the multi-cycle start/done handshake used by the `cordic` datapath. Accepts theta operands on a valid/ready stream and issues each one to a cordic-style responder with a one-cycle `start` pulse. Waits for `done` with a bounded timeout, then presents the result on an output valid/ready stream. It also keeps a running signed sum and a result count, so firmware can batch-evaluate a series without polling per element.

## Interface
- `DATA_W`, 23: width of theta and result words (fixed-point, two's complement).
- `ACC_W`, 32: accumulator width; must be ≥ `DATA_W`.
- `TIMEOUT`, 64: maximum cycles spent in WAIT before the transaction is abandoned; must be ≥ 2.

Ports (one clock; reset is synchronous and active-low):
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-low; `reset==0` at an edge clears all state.
- `in_valid`  in  1  theta operand available.
- `in_ready`  out  1  block can accept an operand.
- `in_theta`  in  DATA_W  operand.
- `co_clk_en`  out  1  clock enable to the responder.
- `co_start`  out  1  one-cycle start pulse to the responder.
- `co_theta`  out  DATA_W  operand to the responder; stable from ISSUE through WAIT.
- `co_done`  in  1  responder completion.
- `co_result`  in  DATA_W  responder result; sampled only when `co_done` is seen in WAIT.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer accepts the result.
- `out_result`  out  DATA_W  captured result, or 0 on timeout.
- `out_timeout`  out  1  qualifies `out_result`: 1 means the responder never answered.
- `acc_clear`  in  1  synchronous clear of `acc_sum` and `result_count`.
- `acc_sum`  out  ACC_W  running sum of sign-extended successful results.
- `result_count`  out  16  number of successful results since reset or clear.

## Operation
- FSM states: IDLE, ISSUE, WAIT, HOLD.
- **IDLE**
  - `in_ready=1`.
  - When `in_valid&in_ready`, latch `in_theta` into `co_theta` and go to ISSUE.
- **ISSUE**
  - `co_start=1` and `co_clk_en=1` for exactly this cycle.
  - Clear the timeout counter and go to WAIT.
- **WAIT**
  - `co_clk_en=1` and the timeout counter increments.
  - If `co_done=1`: capture `co_result` into `out_result` and set `out_timeout=0`.
    - `acc_sum += sext(co_result)` and `result_count += 1`.
    - Go to HOLD.
  - Else if the counter reaches `TIMEOUT-1`: set `out_result=0`, `out_timeout=1`, no accumulate, no count; go to HOLD.
  - If `co_done` and the timeout fall in the same cycle, `done` wins.
- **HOLD**
  - `out_valid=1`; `out_result` and `out_timeout` are held stable.
  - On `out_ready=1`, go to IDLE.
- Outside ISSUE/WAIT, `co_clk_en=0` and `co_start=0`.
- `co_done` is ignored in IDLE, ISSUE and HOLD, so a stale `done` never produces a result.
- `in_ready` is 0 in ISSUE/WAIT/HOLD: one transaction is in flight at a time.
- **Accumulator**
  - Next value is `acc_clear ? (add ? sext(co_result) : 0) : acc_sum + (add ? sext(co_result) : 0)`. A clear coincident with a result keeps only that result.
  - `result_count` follows the same rule.
  - Both wrap modulo 2^width with no saturation.
- **Reset**
  - `reset==0` forces IDLE from any state, including mid-WAIT.
  - All outputs go to 0: `in_ready`, `co_*`, `out_valid`, `out_result`, `out_timeout`, `acc_sum`, `result_count`. `in_ready` becomes 1 on the first cycle after reset is released.

## Timing
- Operand accepted at edge t. `co_start` is high during cycle t+1.
- Earliest `co_done` counts in cycle t+2. If `done` arrives in cycle t+1+k (k≥1), `out_valid` rises at t+2+k.
- `acc_sum` and `result_count` update at the same edge that raises `out_valid`.
- Timeout: `out_valid` with `out_timeout=1` rises `TIMEOUT+1` cycles after `co_start`.
- Result accepted at edge h (`out_valid&out_ready`). `in_ready=1` in cycle h+1. Minimum back-to-back period is k+3 cycles.
- No combinational path from `in_valid`, `out_ready` or `co_done` to any output.

## Structure
- Shared package `cordic_pkg` holds:
  - `DATA_W` default and the `fixed_t` typedef (`logic signed [DATA_W-1:0]`).
  - The state enum `init_state_t`.
- No sub-module: the FSM, timeout counter and accumulator live in one module. The accumulator may be split out as `cordic_acc` if reused.

## Test plan
- **Single op.** Responder model asserts `done` 3 cycles after `start` with result 0x1B5C28; theta=0x200000 with `out_ready=1`.
  - Required: one `co_start` pulse; `out_result=0x1B5C28` 4 cycles after `start`; `acc_sum=0x1B5C28`; `result_count=1`.
- **Negative accumulate.** Results 0x7FFFFF (-1 in 23 bits) then 0x000005.
  - Required: `acc_sum`=0xFFFFFFFF then 0x00000004; `result_count=2`.
- **Timeout.** Responder never asserts `done`; `TIMEOUT=8`.
  - Required: `out_valid` with `out_timeout=1`, `out_result=0`, 9 cycles after `start`; `acc_sum` and `result_count` unchanged.
- **Backpressure plus stale done.** Hold `out_ready=0` for 5 cycles while pulsing `co_done` in HOLD; also send a second operand.
  - Required: `out_result` stable; `in_ready=0`; no second `start` until the cycle after acceptance; extra `done` ignored.
- **Clear collision.** Assert `acc_clear` in the same cycle `co_done` arrives, with `acc_sum`=100 and result=7.
  - Required: `acc_sum=7`, `result_count=1`.
- **Reset mid-WAIT.** Drive `reset=0` for 1 cycle in WAIT; responder then asserts `done`.
  - Required: all outputs 0 after the reset edge; late `done` ignored; `in_ready=1` on the cycle after release.
